pkt_sink: RTL and testbench

Testbench-side packet receiver that terminates one many-core NoC egress port under credit-based flow control. It is the complement of the MA/App injectors. It buffers incoming flits and parses each packet as header flit, size flit, then `size` payload flits. Payload is emitted on a valid/ready stream with header and size side information, so benches can check, log or count traffic leaving the mesh.

---
 rtl/pkt_sink_pkg.sv | 12 +
 rtl/pkt_sink_flit_fifo.sv | 59 +++++
 rtl/pkt_sink.sv | 167 ++++++++++++++++
 tb/tb_pkt_sink.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sink_pkg.sv
// Shared definitions for the NoC egress packet sink: parser states and the default flit width.
package pkt_sink_pkg;

  localparam int FLIT_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    HEADER,
    SIZE,
    PAYLOAD
  } state_e;

endpackage

// File: rtl/pkt_sink_flit_fifo.sv
// Circular flit buffer with registered occupancy; push is ignored when full, pop when empty.
module flit_fifo
  import pkt_sink_pkg::*;
#(
  parameter int FLIT_SIZE    = FLIT_SIZE_DEF,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic [FLIT_SIZE-1:0]            data_i,
  input  logic                            pop_i,
  output logic [FLIT_SIZE-1:0]            data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(BUFFER_DEPTH):0]   count_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [FLIT_SIZE-1:0] mem_q [BUFFER_DEPTH];
  logic                 push_ok;
  logic                 pop_ok;

  assign full_o  = (count_q == CW'(BUFFER_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pkt_sink.sv
// Egress packet sink: buffers credited flits, parses header/size/payload and streams payload beats.
module pkt_sink
  import pkt_sink_pkg::*;
#(
  parameter int FLIT_SIZE    = FLIT_SIZE_DEF,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [FLIT_SIZE-1:0] out_data_o,
  output logic                 out_first_o,
  output logic                 out_last_o,
  output logic [FLIT_SIZE-1:0] hdr_o,
  output logic [FLIT_SIZE-1:0] size_o,
  output logic                 pkt_done_o,
  output logic [31:0]          pkt_count_o
);

  localparam int CW = $clog2(BUFFER_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] rem_q, rem_d;
  logic [FLIT_SIZE-1:0] hdr_q, hdr_d;
  logic [FLIT_SIZE-1:0] size_q, size_d;
  logic [FLIT_SIZE-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_first_q, out_first_d;
  logic                 out_last_q, out_last_d;
  logic                 first_pend_q, first_pend_d;
  logic                 done_q, done_d;
  logic [31:0]          cnt_q, cnt_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [FLIT_SIZE-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 out_free;
  logic [1:0]           done_inc;

  // Credit looks only at registered occupancy so it never loops back through rx_i.
  assign credit_o  = (fifo_count != CW'(BUFFER_DEPTH));
  assign fifo_push = rx_i && !fifo_full;

  flit_fifo #(
    .FLIT_SIZE   (FLIT_SIZE),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (fifo_push),
    .data_i (data_i),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    hdr_d        = hdr_q;
    size_d       = size_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    first_pend_d = first_pend_q;
    out_free     = !out_valid_q || out_ready_i;
    fifo_pop     = 1'b0;
    done_inc     = 2'(out_valid_q && out_ready_i && out_last_q);

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      HEADER: begin
        fifo_pop = !fifo_empty;
        if (!fifo_empty) begin
          hdr_d   = fifo_data;
          state_d = SIZE;
        end
      end
      SIZE: begin
        fifo_pop = !fifo_empty;
        if (!fifo_empty) begin
          size_d = fifo_data;
          rem_d  = fifo_data;
          if (fifo_data == '0) begin
            done_inc = done_inc + 2'd1;
            state_d  = HEADER;
          end else begin
            first_pend_d = 1'b1;
            state_d      = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        fifo_pop = !fifo_empty && out_free;
        if (!fifo_empty && out_free) begin
          out_data_d   = fifo_data;
          out_valid_d  = 1'b1;
          out_first_d  = first_pend_q;
          out_last_d   = (rem_q == FLIT_SIZE'(1));
          first_pend_d = 1'b0;
          rem_d        = rem_q - FLIT_SIZE'(1);
          if (rem_q == FLIT_SIZE'(1)) state_d = HEADER;
        end
      end
      default: state_d = HEADER;
    endcase

    // A zero-size completion and a last-beat handshake in one cycle merge into one pulse.
    done_d = (done_inc != 2'd0);
    cnt_d  = cnt_q + 32'(done_inc);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= HEADER;
      rem_q        <= '0;
      hdr_q        <= '0;
      size_q       <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      first_pend_q <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      hdr_q        <= hdr_d;
      size_q       <= size_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      first_pend_q <= first_pend_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    out_data_q <= out_data_d;
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;
  assign hdr_o       = hdr_q;
  assign size_o      = size_q;
  assign pkt_done_o  = done_q;
  assign pkt_count_o = cnt_q;

endmodule

// File: tb/tb_pkt_sink.sv
// Randomised scoreboard bench for pkt_sink: packets are queued as expected beats, a monitor pops and compares.
module tb_pkt_sink;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         rx_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         out_ready_i = 1'b0;
  logic         credit_o;
  logic         out_valid_o;
  logic [W-1:0] out_data_o;
  logic         out_first_o;
  logic         out_last_o;
  logic [W-1:0] hdr_o;
  logic [W-1:0] size_o;
  logic         pkt_done_o;
  logic [31:0]  pkt_count_o;

  pkt_sink #(.FLIT_SIZE(W), .BUFFER_DEPTH(8)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .credit_o   (credit_o),
    .data_i     (data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_first_o(out_first_o),
    .out_last_o (out_last_o),
    .hdr_o      (hdr_o),
    .size_o     (size_o),
    .pkt_done_o (pkt_done_o),
    .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    bit           first;
    bit           last;
    logic [W-1:0] hdr;
    logic [W-1:0] size;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] pl_q[$];
  int           checks = 0;
  int           failures = 0;
  int           pkt_exp = 0;
  int           done_seen = 0;
  int           accepted = 0;
  bit           ready_rand = 1'b0;
  bit           ready_force = 1'b0;
  bit           gaps = 1'b0;
  bit           sender_busy = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Consumer ready changes just after the rising edge so it is stable at the sampling edge.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  initial forever begin : monitor
    logic [31:0] prev_cnt;
    logic [31:0] delta;
    bit          last_hs;
    beat_t       e;
    @(negedge clk);
    if (!rst_ni) begin
      prev_cnt = '0;
      last_hs  = 1'b0;
    end else begin
      if (last_hs) check("done_after_last", {31'd0, pkt_done_o}, 32'd1);
      last_hs = 1'b0;
      delta = pkt_count_o - prev_cnt;
      if (delta > 32'd2) fail("count_step");
      check("done_vs_count", {31'd0, pkt_done_o}, {31'd0, (delta != 0)});
      if (pkt_done_o) done_seen++;
      prev_cnt = pkt_count_o;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data_o, e.data);
          check("beat_first", {31'd0, out_first_o}, {31'd0, e.first});
          check("beat_last", {31'd0, out_last_o}, {31'd0, e.last});
          if (e.first && !e.last) begin
            check("beat_hdr", hdr_o, e.hdr);
            check("beat_size", size_o, e.size);
          end
        end
        last_hs = out_last_o;
      end
    end
  end

  task automatic send_flit(input logic [W-1:0] d);
    int guard;
    if (gaps) while ($urandom_range(0, 3) == 0) @(negedge clk);
    rx_i   = 1'b1;
    data_i = d;
    guard  = 0;
    while (!credit_o && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      fail("send_timeout");
      $fatal(1, "sender stalled");
    end
    @(negedge clk);
    accepted++;
    rx_i = 1'b0;
  endtask

  task automatic queue_expect(input logic [W-1:0] hdr);
    for (int i = 0; i < pl_q.size(); i++)
      exp_q.push_back('{pl_q[i], (i == 0), (i == pl_q.size() - 1), hdr, W'(pl_q.size())});
    pkt_exp++;
  endtask

  task automatic send_pkt(input logic [W-1:0] hdr);
    logic [W-1:0] p[$];
    p = pl_q;
    sender_busy = 1'b1;
    queue_expect(hdr);
    send_flit(hdr);
    send_flit(W'(p.size()));
    for (int i = 0; i < p.size(); i++) send_flit(p[i]);
    sender_busy = 1'b0;
  endtask

  task automatic fill_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(W'($urandom));
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || sender_busy) && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40000) fail("drain_timeout");
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    rx_i   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_credit", {31'd0, credit_o}, 32'd1);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_first", {31'd0, out_first_o}, 32'd0);
    check("rst_last", {31'd0, out_last_o}, 32'd0);
    check("rst_hdr", hdr_o, 32'd0);
    check("rst_size", size_o, 32'd0);
    check("rst_done", {31'd0, pkt_done_o}, 32'd0);
    check("rst_count", pkt_count_o, 32'd0);
    exp_q.delete();
    pkt_exp   = 0;
    done_seen = 0;
    rst_ni    = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    do_reset();

    // Back-to-back packet
    ready_force = 1'b1;
    pl_q = '{32'hA1, 32'hA2, 32'hA3};
    send_pkt(32'h0000_0101);
    drain();
    check("b2b_count", pkt_count_o, 32'd1);
    check("b2b_hdr", hdr_o, 32'h101);
    check("b2b_size", size_o, 32'd3);
    check("b2b_pulses", 32'(done_seen), 32'd1);

    // Zero-size packet, then a normal one
    do_reset();
    pl_q.delete();
    send_pkt(32'h55);
    drain();
    check("zero_count", pkt_count_o, 32'd1);
    check("zero_hdr", hdr_o, 32'h55);
    check("zero_size", size_o, 32'd0);
    check("zero_pulses", 32'(done_seen), 32'd1);
    fill_payload(2);
    send_pkt(32'h66);
    drain();
    check("after_zero_count", pkt_count_o, 32'd2);
    check("after_zero_hdr", hdr_o, 32'h66);

    // Backpressure to full, then steady push/pop at occupancy 7
    do_reset();
    ready_force = 1'b0;
    repeat (2) @(negedge clk);
    fill_payload(40);
    accepted = 0;
    sender_busy = 1'b1;
    fork
      send_pkt(32'h0B0B);
    join_none
    guard = 0;
    while (credit_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("bp_accepted", 32'(accepted), 32'd11);
    check("bp_credit", {31'd0, credit_o}, 32'd0);
    check("bp_valid", {31'd0, out_valid_o}, 32'd1);
    check("bp_head_data", out_data_o, pl_q[0]);
    repeat (5) @(negedge clk);
    check("bp_hold_data", out_data_o, pl_q[0]);
    check("bp_still_11", 32'(accepted), 32'd11);
    ready_force = 1'b1;
    guard = 0;
    while (!credit_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 20; i++) begin
      check("occ7_credit", {31'd0, credit_o}, 32'd1);
      check("occ7_count", W'(u_dut.fifo_count), 32'd7);
      @(negedge clk);
    end
    drain();
    check("bp_count", pkt_count_o, 32'd1);

    // Reset after 2 of 5 payload flits
    fill_payload(5);
    queue_expect(32'h77);
    send_flit(32'h77);
    send_flit(32'd5);
    send_flit(pl_q[0]);
    send_flit(pl_q[1]);
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    check("post_rst_count", pkt_count_o, 32'd0);
    fill_payload(1);
    send_pkt(32'h88);
    drain();
    check("fresh_count", pkt_count_o, 32'd1);
    check("fresh_pulses", 32'(done_seen), 32'd1);

    // Random stress
    do_reset();
    ready_rand = 1'b1;
    gaps = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      fill_payload($urandom_range(0, 16));
      send_pkt(W'($urandom));
    end
    drain();
    check("stress_count", pkt_count_o, 32'd1000);
    check("stress_expected", 32'(pkt_exp), 32'd1000);
    check("stress_queue_empty", 32'(exp_q.size()), 32'd0);
    ready_rand = 1'b0;
    gaps = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
